uart_transmitter: RTL and testbench
===================================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter WTIME, default 16'h28B0: clocks per bit period (16-bit unsigned).
REQ-002 SHALL have parameter DEPTH_LOG2, default 2: log2 of transmit FIFO depth (depth 4 at default).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock, synchronous, active-high.
REQ-005 SHALL have port valid  input  1  upstream byte offered.
REQ-006 SHALL have port data  input  8  byte to send, sampled when valid & ready.
REQ-007 SHALL have port ready  output  1  FIFO can accept a byte this cycle.
REQ-008 SHALL have port tx  output  1  serial line, registered, idle high.
REQ-009 SHALL have port busy  output  1  high while the shifter is active or the FIFO is non-empty.

Function
REQ-010 SHALL accept a byte into the FIFO on any rising edge where valid & ready; data is held in FIFO order.
REQ-011 SHALL drive ready = ~full & ~rst, combinationally, with no dependence on valid.
REQ-012 SHALL run a shifter FSM with states IDLE, START, DATA, PARITY, STOP; PARITY exists only per REQ-024.
REQ-013 IDLE -> START: SHALL pop the FIFO head on the first edge where the FIFO is non-empty; tx = 0 from that edge.
REQ-014 Write-to-line latency: a byte written at edge N into an empty FIFO with an idle shifter SHALL give tx = 0 after edge N+1.
REQ-015 Every bit (start, each data bit, parity, stop) SHALL hold tx for exactly max(WTIME,2) clocks; WTIME values 0 and 1 behave as 2.
REQ-016 Bit timer SHALL be a down-counter, at least 16 bits wide, reloaded at each bit boundary and never wrapping below 0.
REQ-017 DATA SHALL send 8 bits LSB first; the bit index runs 0..7 and then advances to the next state (PARITY or STOP).
REQ-018 STOP SHALL drive tx = 1 for one bit period, then go to START if the FIFO is non-empty (no idle gap) or to IDLE otherwise.
REQ-019 Simultaneous FIFO push and pop SHALL both take effect; occupancy stays unchanged; full is impossible during a pop from full.
REQ-020 FIFO pointers SHALL wrap modulo 2**DEPTH_LOG2; occupancy count SHALL be DEPTH_LOG2+1 bits wide.
REQ-021 tx SHALL be 1 in IDLE; no glitches, since it comes from a flop.

Reset
REQ-022 With rst high at an edge: tx=1, FSM=IDLE, FIFO empty, timer and bit index cleared, busy=0; ready=0 while rst is high and 1 on the first cycle after.
REQ-023 Reset mid-frame SHALL abort the frame: tx=1 after that edge; the queued bytes and the partial byte are discarded.

Configuration
REQ-024 With macro UART_TX_PARITY_EN defined: an even-parity bit (XOR of the 8 data bits) is sent in PARITY between data bit 7 and stop; frame = 11 bits.
REQ-025 With UART_TX_PARITY_EN undefined: the PARITY state and its logic are absent; DATA goes directly to STOP; frame = 10 bits.

Verification (WTIME=4, DEPTH_LOG2=2 unless stated)
REQ-026 Send 0x55 with the line idle -> tx = 0,1,0,1,0,1,0,1,0,1, each held 4 clocks, first 0 one edge after accept; busy falls after stop.
REQ-027 Hold valid high with 6 bytes, no parity -> 5 accepted (1 in shifter + 4 queued), then ready=0; frames go back-to-back with no idle cycle between stop and start.
REQ-028 Assert rst for one cycle during data bit 3 of 0xA3 with 2 bytes queued -> tx=1 next edge; no further frames; busy=0; ready=1 after reset.
REQ-029 UART_TX_PARITY_EN defined, send 0x07 -> parity bit 1; send 0x03 -> parity bit 0; each frame 11 bit periods.
REQ-030 WTIME=1, send 0x00 -> each bit held 2 clocks; frame lasts 20 clocks (no parity).
REQ-031 Push on the same edge as a pop from a 4-full FIFO while valid stays high -> byte accepted on the edge after ready rises; no loss or duplication; output order = input order.

Source files
------------

// File: rtl/uart_transmitter.sv
// FIFO-buffered UART transmitter (8N1) with a flop-driven serial line.
// Define UART_TX_PARITY_EN to add an even-parity bit between data bit 7 and stop (8E1).
module uart_transmitter #(
    parameter logic [15:0] WTIME      = 16'h28B0,
    parameter int          DEPTH_LOG2 = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx,
    output logic       busy
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    // Reload value is one less than the bit period; periods below 2 clocks are clamped to 2.
    localparam logic [15:0] BIT_RELOAD = (WTIME < 16'd2) ? 16'd1 : (WTIME - 16'd1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} state_t;
`else
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4} state_t;
`endif

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

    logic [7:0]            mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic                  push_s;
    logic                  pop_s;
    logic                  full_s;
    logic                  empty_s;

    state_t      state_r, state_s;
    logic [15:0] timer_r, timer_s;
    logic [2:0]  bit_idx_r, bit_idx_s;
    logic [7:0]  shift_r, shift_s;
    logic        tx_r, tx_s;

    assign full_s  = (count_r == FULL_CNT);
    assign empty_s = (count_r == '0);
    assign ready   = ~full_s & ~rst;
    assign push_s  = valid & ready;
    assign tx      = tx_r;
    assign busy    = (state_r != IDLE) | ~empty_s;

    // FIFO storage write port; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= data;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + DEPTH_LOG2'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + DEPTH_LOG2'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (DEPTH_LOG2 + 1)'(1);
                2'b01:   count_r <= count_r - (DEPTH_LOG2 + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Shifter state register; tx is the registered copy of the next line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            timer_r   <= 16'd0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
            tx_r      <= 1'b1;
        end else begin
            state_r   <= state_s;
            timer_r   <= timer_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
            tx_r      <= tx_s;
        end
    end

    // Next-state logic: each bit lasts until the down-counter reaches zero.
    always_comb begin
        state_s   = state_r;
        timer_s   = timer_r;
        bit_idx_s = bit_idx_r;
        shift_s   = shift_r;
        tx_s      = tx_r;
        pop_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    pop_s     = 1'b1;
                    state_s   = START;
                    tx_s      = 1'b0;
                    timer_s   = BIT_RELOAD;
                    shift_s   = mem_r[rd_ptr_r];
                    bit_idx_s = 3'd0;
                end else begin
                    tx_s    = 1'b1;
                    timer_s = 16'd0;
                end
            end
            START: begin
                if (timer_r == 16'd0) begin
                    state_s   = DATA;
                    tx_s      = shift_r[0];
                    timer_s   = BIT_RELOAD;
                    bit_idx_s = 3'd0;
                end else begin
                    timer_s = timer_r - 16'd1;
                end
            end
            DATA: begin
                if (timer_r == 16'd0) begin
                    timer_s = BIT_RELOAD;
                    if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_s = PARITY;
                        tx_s    = even_parity(shift_r);
`else
                        state_s = STOP;
                        tx_s    = 1'b1;
`endif
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                        tx_s      = shift_r[bit_idx_r + 3'd1];
                    end
                end else begin
                    timer_s = timer_r - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (timer_r == 16'd0) begin
                    state_s = STOP;
                    tx_s    = 1'b1;
                    timer_s = BIT_RELOAD;
                end else begin
                    timer_s = timer_r - 16'd1;
                end
            end
`endif
            STOP: begin
                if (timer_r == 16'd0) begin
                    // Chain straight into the next start bit when more bytes are queued.
                    if (!empty_s) begin
                        pop_s     = 1'b1;
                        state_s   = START;
                        tx_s      = 1'b0;
                        timer_s   = BIT_RELOAD;
                        shift_s   = mem_r[rd_ptr_r];
                        bit_idx_s = 3'd0;
                    end else begin
                        state_s = IDLE;
                        tx_s    = 1'b1;
                        timer_s = 16'd0;
                    end
                end else begin
                    timer_s = timer_r - 16'd1;
                end
            end
            default: begin
                state_s   = IDLE;
                tx_s      = 1'b1;
                timer_s   = 16'd0;
                bit_idx_s = 3'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: a WTIME=4 instance decoded by a line monitor,
// plus a WTIME=1 instance sampled directly.
module tb_uart_transmitter;
    localparam int P = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       valid, ready, tx, busy;
    logic [7:0] data;
    logic       valid2, ready2, tx2, busy2;
    logic [7:0] data2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_transmitter #(.WTIME(16'd4), .DEPTH_LOG2(2)) dut (
        .clk(clk), .rst(rst), .valid(valid), .data(data),
        .ready(ready), .tx(tx), .busy(busy)
    );

    uart_transmitter #(.WTIME(16'd1), .DEPTH_LOG2(2)) dut2 (
        .clk(clk), .rst(rst), .valid(valid2), .data(data2),
        .ready(ready2), .tx(tx2), .busy(busy2)
    );

    // Line monitor for dut: decodes frames, flags bits not held P clocks, records idle gap.
    logic [7:0] rx_q [$];
    int         gap_q [$];
    bit         err_q [$];
    bit         par_q [$];
    int         mon_cyc, mon_bit, mon_ph, idle_cnt, frame_gap;
    bit         in_frame, cur_err, cur_par;
    logic [7:0] cur_byte;

    always @(negedge clk) begin
        if (rst) begin
            in_frame = 1'b0;
            idle_cnt = 0;
        end else begin
            if (!in_frame && tx === 1'b0) begin
                in_frame  = 1'b1;
                mon_cyc   = 0;
                cur_err   = 1'b0;
                cur_byte  = 8'h00;
                cur_par   = 1'b0;
                frame_gap = idle_cnt;
            end
            if (in_frame) begin
                mon_bit = mon_cyc / P;
                mon_ph  = mon_cyc % P;
                if (mon_bit == 0) begin
                    if (tx !== 1'b0) cur_err = 1'b1;
                end else if (mon_bit <= 8) begin
                    if (mon_ph == 0) cur_byte[mon_bit-1] = tx;
                    else if (tx !== cur_byte[mon_bit-1]) cur_err = 1'b1;
                end else if (mon_bit == NB - 1) begin
                    if (tx !== 1'b1) cur_err = 1'b1;
                end else begin
                    if (mon_ph == 0) cur_par = tx;
                    else if (tx !== cur_par) cur_err = 1'b1;
                end
                mon_cyc++;
                if (mon_cyc == NB * P) begin
                    rx_q.push_back(cur_byte);
                    gap_q.push_back(frame_gap);
                    err_q.push_back(cur_err);
                    par_q.push_back(cur_par);
                    in_frame = 1'b0;
                    idle_cnt = 0;
                end
            end else begin
                idle_cnt++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_frames(input int n, input int budget);
        int c = 0;
        while (rx_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        check("frame_timeout", 32'(rx_q.size() >= n), 32'd1);
    endtask

    logic [7:0] sb [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66, 8'h99};
    int k, cnt, nq;
    bit acc;

    initial begin
        rst = 1'b1; valid = 1'b0; data = 8'h00; valid2 = 1'b0; data2 = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", ready, 1'b0);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", ready, 1'b1);

        // Single byte 0x55 from idle: start bit one edge after accept.
        valid = 1'b1; data = 8'h55;
        @(negedge clk);
        valid = 1'b0;
        check("lat_tx_before", tx, 1'b1);
        check("lat_busy", busy, 1'b1);
        @(negedge clk);
        check("lat_tx_start", tx, 1'b0);
        wait_frames(1, 100);
        check("b55_byte", rx_q[0], 8'h55);
        check("b55_timing", err_q[0], 1'b0);
        check("b55_busy_end", busy, 1'b0);
        check("b55_tx_idle", tx, 1'b1);

        // Hold valid with six bytes: five fit (one in shifter, four queued).
        k = 0; valid = 1'b1; data = sb[0]; acc = ready;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (acc) begin
                k++;
                data = (k < 6) ? sb[k] : 8'h00;
            end
            acc = ready;
        end
        check("stream_accepted", k, 5);
        check("stream_full_ready", ready, 1'b0);
        cnt = 0;
        while (k < 6 && cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (acc) k++;
            acc = ready;
        end
        valid = 1'b0;
        check("stream_last_accept", k, 6);
        wait_frames(7, 400);
        for (int i = 0; i < 6; i++) begin
            check("stream_byte", rx_q[i+1], sb[i]);
            check("stream_timing", err_q[i+1], 1'b0);
        end
        for (int i = 2; i < 7; i++) begin
            check("stream_gap", gap_q[i], 0);
        end

        // Reset during data bit 3 of 0xA3 with two bytes queued.
        valid = 1'b1; data = 8'hA3;
        @(negedge clk);
        data = 8'h5A;
        @(negedge clk);
        data = 8'hC3;
        @(negedge clk);
        valid = 1'b0;
        repeat (15) @(negedge clk);
        check("mid_bit3_tx", tx, 1'b0);
        check("mid_busy", busy, 1'b1);
        nq = rx_q.size();
        #1 rst = 1'b1;
        @(negedge clk);
        check("abort_tx", tx, 1'b1);
        check("abort_ready_low", ready, 1'b0);
        check("abort_busy", busy, 1'b0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_ready_after", ready, 1'b1);
        repeat (150) @(negedge clk);
        check("abort_no_frames", rx_q.size(), nq);
        check("abort_tx_idle", tx, 1'b1);
        check("abort_busy_idle", busy, 1'b0);

        // WTIME=1 instance: every bit lasts two clocks.
        valid2 = 1'b1; data2 = 8'h00;
        @(negedge clk);
        valid2 = 1'b0;
        check("w1_tx_before", tx2, 1'b1);
        @(negedge clk);
        for (int i = 0; i < NB * 2; i++) begin
            check("w1_frame", tx2, (i >= (NB - 1) * 2) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        check("w1_tx_after", tx2, 1'b1);
        check("w1_busy_after", busy2, 1'b0);

`ifdef UART_TX_PARITY_EN
        // 0x07 has odd weight (parity 1); 0x03 has even weight (parity 0).
        nq = rx_q.size();
        valid = 1'b1; data = 8'h07;
        @(negedge clk);
        data = 8'h03;
        @(negedge clk);
        valid = 1'b0;
        wait_frames(nq + 2, 200);
        check("par07_byte", rx_q[nq], 8'h07);
        check("par07_bit", par_q[nq], 1'b1);
        check("par07_timing", err_q[nq], 1'b0);
        check("par03_byte", rx_q[nq+1], 8'h03);
        check("par03_bit", par_q[nq+1], 1'b0);
        check("par03_timing", err_q[nq+1], 1'b0);
        check("par03_gap", gap_q[nq+1], 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
